// File: rtl/commit_trace_emitter.sv
// Commit-trace producer: gathers up to six architectural write events per cycle, stores each
// cycle's group atomically in a FIFO and streams one record per cycle to a trace sink.
module commit_trace_emitter #(
  parameter int DEPTH     = 16,
  parameter int STALL_LVL = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we_a,
  input  logic [15:0] mem_addr_a,
  input  logic [31:0] mem_data_a,
  input  logic        reg_we_a,
  input  logic [4:0]  reg_waddr_a,
  input  logic [31:0] reg_wdata_a,
  input  logic        hilo_we_a,
  input  logic [63:0] hilo_a,
  input  logic        mem_we_b,
  input  logic [15:0] mem_addr_b,
  input  logic [31:0] mem_data_b,
  input  logic        reg_we_b,
  input  logic [4:0]  reg_waddr_b,
  input  logic [31:0] reg_wdata_b,
  input  logic        hilo_we_b,
  input  logic [63:0] hilo_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [15:0] out_addr,
  output logic [63:0] out_data,
  output logic [31:0] out_cycle,
  output logic        stall_req,
  output logic        overflow,
  output logic [15:0] drop_cnt
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int NEV = 6;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [63:0] data;
  } ev_t;

  typedef struct packed {
    ev_t         ev;
    logic [31:0] cycle;
  } rec_t;

  ev_t  [NEV-1:0]        ev;
  logic [NEV-1:0]        ev_v;
  logic [NEV-1:0][2:0]   ev_pos;
  logic [2:0]            ev_cnt;
  logic [NEV-1:0][AW-1:0] wslot;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] occ, occ_d;
  logic [PW:0]   free_ap;
  logic          pop, push, drop, fits;
  logic [31:0]   cycle_q, cycle_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;
  logic [16:0]   dsum;
  rec_t          mem_q [DEPTH];
  rec_t          head;

  // Candidate events in canonical order: mem_a, reg_a, hilo_a, mem_b, reg_b, hilo_b
  always_comb begin
    ev[0] = '{kind: 2'd0, addr: mem_addr_a,           data: {32'b0, mem_data_a}};
    ev[1] = '{kind: 2'd1, addr: {11'b0, reg_waddr_a}, data: {32'b0, reg_wdata_a}};
    ev[2] = '{kind: 2'd2, addr: 16'h0000,             data: hilo_a};
    ev[3] = '{kind: 2'd0, addr: mem_addr_b,           data: {32'b0, mem_data_b}};
    ev[4] = '{kind: 2'd1, addr: {11'b0, reg_waddr_b}, data: {32'b0, reg_wdata_b}};
    ev[5] = '{kind: 2'd2, addr: 16'h0000,             data: hilo_b};
  end

  // Writes to r0 are architecturally invisible, so they never produce a record
  assign ev_v = {hilo_we_b, reg_we_b & (reg_waddr_b != 5'd0), mem_we_b,
                 hilo_we_a, reg_we_a & (reg_waddr_a != 5'd0), mem_we_a};

  // Prefix count compacts the qualified events into consecutive slots
  always_comb begin
    ev_cnt = 3'd0;
    for (int i = 0; i < NEV; i++) begin
      ev_pos[i] = ev_cnt;
      ev_cnt    = ev_cnt + {2'b0, ev_v[i]};
    end
  end

  always_comb begin
    for (int i = 0; i < NEV; i++) wslot[i] = wptr_q[AW-1:0] + AW'(ev_pos[i]);
  end

  assign occ       = wptr_q - rptr_q;
  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;

  // A slot freed by this edge's pop is usable by this edge's push
  assign free_ap = (PW+1)'(DEPTH) - {1'b0, occ} + {{PW{1'b0}}, pop};
  assign fits    = {{(PW-2){1'b0}}, ev_cnt} <= free_ap;
  assign push    = (ev_cnt != 3'd0) & fits;
  assign drop    = (ev_cnt != 3'd0) & ~fits;

  always_comb begin
    wptr_d  = wptr_q + (push ? PW'(ev_cnt) : '0);
    rptr_d  = rptr_q + {{(PW-1){1'b0}}, pop};
    occ_d   = wptr_d - rptr_d;
    stall_d = ((PW+1)'(DEPTH) - {1'b0, occ_d}) <= (PW+1)'(STALL_LVL);
    cycle_d = cycle_q + 32'd1;
    ovf_d   = ovf_q | drop;
    dsum    = {1'b0, drop_q} + {14'b0, ev_cnt};
    drop_d  = drop_q;
    if (drop) drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cycle_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < NEV; i++) begin
        if (ev_v[i]) mem_q[wslot[i]] <= '{ev: ev[i], cycle: cycle_d};
      end
    end
  end

  assign head      = mem_q[rptr_q[AW-1:0]];
  assign out_kind  = out_valid ? head.ev.kind : 2'd0;
  assign out_addr  = out_valid ? head.ev.addr : 16'd0;
  assign out_data  = out_valid ? head.ev.data : 64'd0;
  assign out_cycle = out_valid ? head.cycle   : 32'd0;
  assign stall_req = stall_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_commit_trace_emitter.sv
// Directed bench for commit_trace_emitter: reset, ordering, backpressure, atomic drop, wrap, async reset.
module tb_commit_trace_emitter;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_we_a, mem_we_b, reg_we_a, reg_we_b, hilo_we_a, hilo_we_b;
  logic [15:0] mem_addr_a, mem_addr_b;
  logic [31:0] mem_data_a, mem_data_b, reg_wdata_a, reg_wdata_b;
  logic [4:0]  reg_waddr_a, reg_waddr_b;
  logic [63:0] hilo_a, hilo_b;
  logic        out_valid, out_ready, stall_req, overflow;
  logic [1:0]  out_kind;
  logic [15:0] out_addr, drop_cnt;
  logic [63:0] out_data;
  logic [31:0] out_cycle;

  int tests = 0;
  int fails = 0;
  logic [31:0] tb_cyc;

  commit_trace_emitter #(.DEPTH(DEPTH), .STALL_LVL(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_we_a(mem_we_a), .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a),
    .reg_we_a(reg_we_a), .reg_waddr_a(reg_waddr_a), .reg_wdata_a(reg_wdata_a),
    .hilo_we_a(hilo_we_a), .hilo_a(hilo_a),
    .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b),
    .reg_we_b(reg_we_b), .reg_waddr_b(reg_waddr_b), .reg_wdata_b(reg_wdata_b),
    .hilo_we_b(hilo_we_b), .hilo_b(hilo_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_addr(out_addr), .out_data(out_data), .out_cycle(out_cycle),
    .stall_req(stall_req), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Expected cycle stamp reference: zero in reset, +1 on every active edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input logic [1:0] k, input logic [15:0] a,
                         input logic [63:0] d, input logic [31:0] c);
    chk({tag, "_valid"}, {95'b0, out_valid}, 96'd1);
    chk({tag, "_rec"}, {14'b0, out_kind, out_addr, out_data}, {14'b0, k, a, d});
    chk({tag, "_cycle"}, {64'b0, out_cycle}, {64'b0, c});
  endtask

  task automatic idle_ev();
    mem_we_a = 0; reg_we_a = 0; hilo_we_a = 0; mem_we_b = 0; reg_we_b = 0; hilo_we_b = 0;
    mem_addr_a = '0; mem_data_a = '0; reg_waddr_a = '0; reg_wdata_a = '0; hilo_a = '0;
    mem_addr_b = '0; mem_data_b = '0; reg_waddr_b = '0; reg_wdata_b = '0; hilo_b = '0;
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic four_ev(input logic [15:0] a0, input logic [4:0] r0,
                         input logic [15:0] a1, input logic [4:0] r1);
    mem_we_a = 1; mem_addr_a = a0; mem_data_a = 32'h4000 + 32'(a0);
    reg_we_a = 1; reg_waddr_a = r0; reg_wdata_a = 32'h5000 + 32'(r0);
    mem_we_b = 1; mem_addr_b = a1; mem_data_b = 32'h4000 + 32'(a1);
    reg_we_b = 1; reg_waddr_b = r1; reg_wdata_b = 32'h5000 + 32'(r1);
  endtask

  logic [1:0]  fk [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
  logic [15:0] fa [6] = '{16'h0010, 16'h0003, 16'h0000, 16'h0020, 16'h001F, 16'h0000};
  logic [63:0] fd [6] = '{64'hDEADBEEF, 64'h33, 64'hAAAA_0000_BBBB_0001,
                          64'hCAFEF00D, 64'h1F1F, 64'h1_0000_0002};
  logic [15:0] ea5 [16];
  logic [1:0]  ek5 [16];

  logic [81:0] sbq [$];
  logic [31:0] sbc [$];

  initial begin
    logic [31:0] stamp;
    logic [81:0] e;
    int sent, got;

    // 1: reset with traffic present
    rst_n = 0; out_ready = 1; idle_ev();
    mem_we_a = 1; reg_we_b = 1; reg_waddr_b = 5'd7; hilo_we_a = 1;
    repeat (3) nx();
    chk("rst_valid", {95'b0, out_valid}, 96'd0);
    chk("rst_ovf", {95'b0, overflow}, 96'd0);
    chk("rst_drop", {80'b0, drop_cnt}, 96'd0);
    chk("rst_stall", {95'b0, stall_req}, 96'd0);
    chk("rst_outs", {14'b0, out_kind, out_addr, out_data}, 96'd0);
    chk("rst_cycle", {64'b0, out_cycle}, 96'd0);
    rst_n = 1; idle_ev();
    reg_we_a = 1; reg_waddr_a = 5'd5; reg_wdata_a = 32'h55;
    nx(); idle_ev();
    chk_rec("first", 2'd1, 16'h0005, 64'h55, 32'd1);
    nx();
    chk("first_popped", {95'b0, out_valid}, 96'd0);

    // 2: single reg write, then a write to r0
    reg_we_a = 1; reg_waddr_a = 5'd2; reg_wdata_a = 32'h0000_0101; stamp = tb_cyc + 1;
    nx(); idle_ev();
    chk_rec("reg2", 2'd1, 16'h0002, 64'h101, stamp);
    reg_we_a = 1; reg_waddr_a = 5'd0; reg_wdata_a = 32'hFFFF;
    nx(); idle_ev();
    chk("r0_none_a", {95'b0, out_valid}, 96'd0);
    nx();
    chk("r0_none_b", {95'b0, out_valid}, 96'd0);

    // 3: all six events in one cycle
    mem_we_a = 1; mem_addr_a = 16'h0010; mem_data_a = 32'hDEADBEEF;
    reg_we_a = 1; reg_waddr_a = 5'd3; reg_wdata_a = 32'h33;
    hilo_we_a = 1; hilo_a = 64'hAAAA_0000_BBBB_0001;
    mem_we_b = 1; mem_addr_b = 16'h0020; mem_data_b = 32'hCAFEF00D;
    reg_we_b = 1; reg_waddr_b = 5'd31; reg_wdata_b = 32'h1F1F;
    hilo_we_b = 1; hilo_b = 64'h1_0000_0002;
    stamp = tb_cyc + 1;
    nx(); idle_ev();
    for (int i = 0; i < 6; i++) begin
      chk_rec($sformatf("six%0d", i), fk[i], fa[i], fd[i], stamp);
      nx();
    end
    chk("six_empty", {95'b0, out_valid}, 96'd0);

    // 4: backpressure, stall threshold, overflow keeps contents
    out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 9)  chk("stall_occ9", {95'b0, stall_req}, 96'd0);
      if (i == 10) begin
        chk("stall_occ10", {95'b0, stall_req}, 96'd1);
        chk("bp_hold", {80'b0, out_addr}, 96'h0100);
      end
      mem_we_a = 1; mem_addr_a = 16'h0100 + 16'(i); mem_data_a = 32'h1000 + i;
      nx(); idle_ev();
    end
    chk("full_stall", {95'b0, stall_req}, 96'd1);
    chk("full_ovf0", {95'b0, overflow}, 96'd0);
    mem_we_a = 1; mem_addr_a = 16'h01FF; mem_data_a = 32'h1FFF;
    nx(); idle_ev();
    chk("ovf_set", {95'b0, overflow}, 96'd1);
    chk("ovf_drop1", {80'b0, drop_cnt}, 96'd1);
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("bp_drain%0d", i), {32'b0, out_addr, 16'b0, out_data[31:0]},
          {32'b0, 16'h0100 + 16'(i), 16'b0, 32'h1000 + i});
      nx();
    end
    chk("bp_empty", {95'b0, out_valid}, 96'd0);

    // 5: atomic drop with 3 free, then accept with pop leaving 4 free
    out_ready = 0;
    for (int i = 0; i < 13; i++) begin
      mem_we_a = 1; mem_addr_a = 16'h0200 + 16'(i); mem_data_a = 32'h2000 + i;
      nx(); idle_ev();
    end
    four_ev(16'h03F0, 5'd9, 16'h03F1, 5'd10);
    nx(); idle_ev();
    chk("atom_drop", {80'b0, drop_cnt}, 96'd5);
    chk("atom_ovf", {95'b0, overflow}, 96'd1);
    out_ready = 1;
    four_ev(16'h0300, 5'd4, 16'h0301, 5'd6);
    nx(); idle_ev();
    chk("atom_keep", {80'b0, drop_cnt}, 96'd5);
    for (int i = 0; i < 12; i++) begin ea5[i] = 16'h0201 + 16'(i); ek5[i] = 2'd0; end
    ea5[12] = 16'h0300; ek5[12] = 2'd0;
    ea5[13] = 16'h0004; ek5[13] = 2'd1;
    ea5[14] = 16'h0301; ek5[14] = 2'd0;
    ea5[15] = 16'h0006; ek5[15] = 2'd1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("atom_rd%0d", i), {77'b0, out_valid, out_kind, out_addr},
          {77'b0, 1'b1, ek5[i], ea5[i]});
      nx();
    end
    chk("atom_empty", {95'b0, out_valid}, 96'd0);

    // 6: wrap stream with random backpressure
    sent = 0; got = 0;
    for (int c = 0; c < 3000 && got < 3 * DEPTH; c++) begin
      nx(); idle_ev();
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("wrap_unexpected", {95'b0, out_valid}, 96'd0);
        end else begin
          chk($sformatf("wrap_rec%0d", got), {14'b0, out_kind, out_addr, out_data},
              {14'b0, sbq.pop_front()});
          chk($sformatf("wrap_cyc%0d", got), {64'b0, out_cycle}, {64'b0, sbc.pop_front()});
        end
        got++;
      end
      if (sent < 3 * DEPTH && sbq.size() < 10 && $urandom_range(0, 2) != 0) begin
        case (sent % 3)
          0: begin
            mem_we_a = 1; mem_addr_a = 16'($urandom); mem_data_a = $urandom;
            e = {2'd0, mem_addr_a, 32'b0, mem_data_a};
          end
          1: begin
            reg_we_b = 1; reg_waddr_b = 5'(1 + sent % 31); reg_wdata_b = $urandom;
            e = {2'd1, 11'b0, reg_waddr_b, 32'b0, reg_wdata_b};
          end
          default: begin
            hilo_we_a = 1; hilo_a = {$urandom, $urandom};
            e = {2'd2, 16'h0000, hilo_a};
          end
        endcase
        sbq.push_back(e);
        sbc.push_back(tb_cyc + 1);
        sent++;
      end
    end
    chk("wrap_count", 96'(got), 96'(3 * DEPTH));
    chk("wrap_noloss", {80'b0, drop_cnt}, 96'd5);

    // Reset mid-stream: valid must drop without a clock edge
    nx(); idle_ev(); out_ready = 0;
    mem_we_a = 1; mem_addr_a = 16'h0AAA; mem_data_a = 32'hAAAA;
    nx(); idle_ev();
    nx();
    chk("mid_valid", {95'b0, out_valid}, 96'd1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", {95'b0, out_valid}, 96'd0);
    chk("mid_rst_ovf", {95'b0, overflow}, 96'd0);
    chk("mid_rst_drop", {80'b0, drop_cnt}, 96'd0);
    nx(); rst_n = 1;
    nx();
    chk("post_rst_empty", {95'b0, out_valid}, 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
